spi_cfg_slave: RTL and testbench

SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

---
 rtl/spi_cfg_slave_if.sv | 10 +
 rtl/spi_cfg_slave.sv | 152 +++++++++++++++
 tb/tb_spi_cfg_slave.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_slave_if.sv
// SPI pin bundle between a configuration master and spi_cfg_slave.
interface spi_cfg_slave_if;
  logic i_spi_clk;
  logic i_spi_mosi;
  logic i_spi_le;
  logic o_spi_miso;

  modport master (output i_spi_clk, output i_spi_mosi, output i_spi_le, input o_spi_miso);
  modport slave  (input i_spi_clk, input i_spi_mosi, input i_spi_le, output o_spi_miso);
endinterface

// File: rtl/spi_cfg_slave.sv
// SPI-programmed bank of 28-bit configuration registers, oversampled in the clk domain.
// Optional register readback over MISO is built when SPI_CFG_READBACK_EN is defined.
module spi_cfg_slave #(
  parameter int          NUM_REGS = 3,
  parameter logic [27:0] RST_VAL  = 28'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_cfg_slave_if.slave         spi,
  output logic [NUM_REGS*28-1:0] o_regs,
  output logic                   o_wr_stb,
  output logic [3:0]             o_wr_addr,
  output logic                   o_frame_err,
  output logic                   o_busy
);
  localparam logic [3:0] NREG4 = 4'(NUM_REGS);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, EVAL = 2'd2} state_t;

  state_t      r_state;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic        r_mosi_s1, r_mosi_s2;
  logic        r_le_s1, r_le_s2, r_le_d;
  logic [31:0] r_word;
  logic [5:0]  r_cnt;
  logic        r_fall_pend;
  logic [27:0] r_regs [NUM_REGS];

  logic        w_sck_rise, w_le_fall, w_le_rise, w_wr_ok, w_rb_cmd;
  logic [3:0]  w_addr;

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_le_fall  = ~r_le_s2 & r_le_d;
  assign w_le_rise  = r_le_s2 & ~r_le_d;
  assign w_addr     = r_word[3:0];
  assign w_wr_ok    = (r_cnt == 6'd32) && (w_addr < NREG4);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign o_regs[28*k +: 28] = r_regs[k];
  end

`ifdef SPI_CFG_READBACK_EN
  logic        r_rb_arm;
  logic [3:0]  r_rb_addr;
  logic [31:0] r_rb_sr;
  logic        r_miso;
  logic [27:0] w_rb_reg;
  logic        w_sck_fall;

  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_rb_cmd   = (r_cnt == 6'd32) && (w_addr == 4'hE) && (r_word[7:4] < NREG4);
  assign spi.o_spi_miso = r_miso;

  // Select the armed readback register.
  always_comb begin
    w_rb_reg = 28'h0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_rb_reg = (r_rb_addr == 4'(k)) ? r_regs[k] : w_rb_reg;
    end
  end
`else
  assign w_rb_cmd       = 1'b0;
  assign spi.o_spi_miso = 1'b0;
`endif

  // Synchronizers keep running through reset so a frame already open at release never looks like a fresh le fall.
  always_ff @(posedge clk) begin
    r_sck_s1  <= spi.i_spi_clk;
    r_sck_s2  <= r_sck_s1;
    r_sck_d   <= r_sck_s2;
    r_mosi_s1 <= spi.i_spi_mosi;
    r_mosi_s2 <= r_mosi_s1;
    r_le_s1   <= spi.i_spi_le;
    r_le_s2   <= r_le_s1;
    r_le_d    <= r_le_s2;
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_word      <= 32'h0;
      r_cnt       <= 6'd0;
      r_fall_pend <= 1'b0;
      o_wr_stb    <= 1'b0;
      o_frame_err <= 1'b0;
      o_wr_addr   <= 4'h0;
      o_busy      <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RST_VAL;
`ifdef SPI_CFG_READBACK_EN
      r_rb_arm  <= 1'b0;
      r_rb_addr <= 4'h0;
      r_rb_sr   <= 32'h0;
      r_miso    <= 1'b0;
`endif
    end else begin
      o_wr_stb    <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= ~r_le_s2;
      case (r_state)
        IDLE: begin
          // A fall seen during EVAL is remembered so back-to-back frames are not lost.
          if (w_le_fall || r_fall_pend) begin
            r_state     <= SHIFT;
            r_cnt       <= 6'd0;
            r_fall_pend <= 1'b0;
`ifdef SPI_CFG_READBACK_EN
            r_rb_sr <= {w_rb_reg, r_rb_addr};
            r_miso  <= r_rb_arm & r_rb_addr[0];
`endif
          end
        end
        SHIFT: begin
          if (w_le_rise) begin
            r_state <= EVAL;
`ifdef SPI_CFG_READBACK_EN
            r_miso  <= 1'b0;
`endif
          end else begin
            if (w_sck_rise) begin
              r_word <= {r_mosi_s2, r_word[31:1]};
              if (r_cnt != 6'd33) r_cnt <= r_cnt + 6'd1;
            end
`ifdef SPI_CFG_READBACK_EN
            if (w_sck_fall && r_rb_arm) begin
              r_rb_sr <= r_rb_sr >> 1;
              r_miso  <= r_rb_sr[1];
            end
`endif
          end
        end
        EVAL: begin
          r_state     <= IDLE;
          r_fall_pend <= w_le_fall;
          o_wr_stb    <= w_wr_ok;
          o_frame_err <= ~w_wr_ok & ~w_rb_cmd;
          if (w_wr_ok) begin
            o_wr_addr <= w_addr;
            for (int k = 0; k < NUM_REGS; k++) begin
              if (w_addr == 4'(k)) r_regs[k] <= r_word[31:4];
            end
          end
`ifdef SPI_CFG_READBACK_EN
          r_rb_arm <= w_rb_cmd;
          if (w_rb_cmd) r_rb_addr <= r_word[7:4];
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cfg_slave.sv
// Randomized self-checking bench for spi_cfg_slave against a frame-level register model.
module tb_spi_cfg_slave;
  localparam int          NR   = 3;
  localparam logic [27:0] RV   = 28'h00C0FFE;
  localparam int          HALF = 8;
`ifdef SPI_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*28-1:0] o_regs;
  logic            o_wr_stb, o_frame_err, o_busy;
  logic [3:0]      o_wr_addr;

  spi_cfg_slave_if u_if();

  spi_cfg_slave #(.NUM_REGS(NR), .RST_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .spi(u_if.slave),
    .o_regs(o_regs), .o_wr_stb(o_wr_stb), .o_wr_addr(o_wr_addr),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [27:0] m_regs [NR];
  logic [3:0]  m_wr_addr;
  logic        m_arm;
  logic [3:0]  m_rb_addr;
  logic [31:0] last_cap;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = RV;
    m_wr_addr = 4'h0;
    m_arm     = 1'b0;
    m_rb_addr = 4'h0;
  endtask

  function automatic logic [NR*28-1:0] pack_regs();
    logic [NR*28-1:0] v;
    for (int k = 0; k < NR; k++) v[k*28 +: 28] = m_regs[k];
    return v;
  endfunction

  // One le-low window of nbits clocks; rst_at >= 0 pulses rst_n before that bit.
  task automatic send_frame(input logic [31:0] w, input int nbits, input int rst_at, input int gap);
    logic [31:0] cap, exp_cap, rb_word;
    logic        armed, did_rst, e_stb, e_err;
    logic [3:0]  a;
    cap = 32'h0; exp_cap = 32'h0; did_rst = 1'b0;
    armed   = m_arm;
    rb_word = {m_regs[m_rb_addr], m_rb_addr};
    u_if.i_spi_le = 1'b0;
    tick(1);
    chk("pulse_width", 128'({o_wr_stb, o_frame_err}), 128'(2'b00));
    tick(HALF - 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(2);
        model_reset();
        armed = 1'b0; did_rst = 1'b1;
        chk("rst_busy", 128'(o_busy), 128'(1'b0));
        chk("rst_regs", 128'(o_regs), 128'(pack_regs()));
        rst_n = 1'b1;
      end
      u_if.i_spi_mosi = (i < 32) ? w[i] : 1'($urandom);
      tick(HALF);
      if (i < 32) begin
        cap[i]     = u_if.o_spi_miso;
        exp_cap[i] = armed & rb_word[i];
      end
      u_if.i_spi_clk = 1'b1;
      tick(HALF);
      if (i == 16) chk("busy_mid", 128'(o_busy), 128'(1'b1));
      u_if.i_spi_clk = 1'b0;
    end
    tick(HALF);
    u_if.i_spi_le = 1'b1;
    last_cap = cap;
    chk("miso_bits", 128'(cap), 128'(exp_cap));
    e_stb = 1'b0; e_err = 1'b0;
    if (!did_rst) begin
      a = w[3:0];
      m_arm = 1'b0;
      if (nbits != 32) e_err = 1'b1;
      else if (a < NR) begin
        m_regs[a] = w[31:4]; m_wr_addr = a; e_stb = 1'b1;
      end else if (RB && a == 4'hE && w[7:4] < NR) begin
        m_arm = 1'b1; m_rb_addr = w[7:4];
      end else e_err = 1'b1;
    end
    tick(3);
    chk("pulse_early", 128'({o_wr_stb, o_frame_err}), 128'(2'b00));
    tick(1);
    chk("pulse", 128'({o_wr_stb, o_frame_err}), 128'({e_stb, e_err}));
    chk("regs", 128'(o_regs), 128'(pack_regs()));
    chk("wr_addr", 128'(o_wr_addr), 128'(m_wr_addr));
    chk("busy_idle", 128'(o_busy), 128'(1'b0));
    if (gap > 4) tick(gap - 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          nb, sel;
    u_if.i_spi_clk = 1'b0; u_if.i_spi_mosi = 1'b0; u_if.i_spi_le = 1'b1;
    rst_n = 1'b0;
    model_reset();
    tick(4);
    chk("rst_regs0", 128'(o_regs), 128'(pack_regs()));
    chk("rst_wr_addr", 128'(o_wr_addr), 128'(4'h0));
    chk("rst_pulses", 128'({o_wr_stb, o_frame_err, o_busy}), 128'(3'b000));
    chk("rst_miso", 128'(u_if.o_spi_miso), 128'(1'b0));
    rst_n = 1'b1;
    tick(4);

    send_frame(32'h1234_5671, 32, -1, 6);
    chk("reg1_value", 128'(o_regs[55:28]), 128'(28'h1234567));
    send_frame(32'h0BAD_BEE0, 31, -1, 6);
    send_frame(32'h0BAD_BEE0, 33, -1, 6);
    send_frame(32'h5555_5555, 32, -1, 6);
    send_frame(32'hCAFE_F002, 32, -1, 6);
    send_frame(32'h7777_7771, 32, 16, 8);
    send_frame(32'h1357_9BD0, 32, -1, 6);

    send_frame(32'hABCD_EF02, 32, -1, 6);
    send_frame(32'h0000_002E, 32, -1, 6);
    send_frame(32'h0000_000F, 32, -1, 6);
`ifdef SPI_CFG_READBACK_EN
    chk("readback_word", 128'(last_cap), 128'(32'hABCD_EF02));
`endif

    send_frame(32'h1111_1110, 32, -1, 4);
    send_frame(32'h2222_2221, 32, -1, 4);

    for (int n = 0; n < 28; n++) begin
      w   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 5)      w[3:0] = 4'($urandom_range(0, NR - 1));
      else if (sel < 7) begin w[3:0] = 4'hE; w[7:4] = 4'($urandom_range(0, 3)); end
      else              w[3:0] = 4'($urandom_range(NR, 15));
      nb = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 40) : 32;
      send_frame(w, nb, ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : -1,
                 $urandom_range(4, 8));
    end
    tick(1);
    chk("pulse_final", 128'({o_wr_stb, o_frame_err}), 128'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
